// File: rtl/windtx_pkg.sv
// -----------------------------------------------------------------------------
// windtx_pkg
// Shared types and constants for the ultrasonic excitation sequencer.
//   windtx_state_t : sweep FSM states
//   WINDTX_LANES   : number of transducers (one drive lane each)
//   WINDTX_CNT_W   : width of the phase and half-period counters
//   lane_onehot()  : slot index -> one-hot lane mask
// -----------------------------------------------------------------------------
package windtx_pkg;

  localparam int WINDTX_LANES   = 4;
  localparam int WINDTX_CNT_W   = 24;
  localparam int WINDTX_PULSE_W = 8;
  localparam int WINDTX_SLOT_W  = $clog2(WINDTX_LANES);

  typedef logic [WINDTX_CNT_W-1:0]   cnt_t;
  typedef logic [WINDTX_PULSE_W-1:0] pulse_cnt_t;
  typedef logic [WINDTX_SLOT_W-1:0]  slot_t;
  typedef logic [WINDTX_LANES-1:0]   lane_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BURST  = 3'd1,
    ST_BLANK  = 3'd2,
    ST_LISTEN = 3'd3,
    ST_GUARD  = 3'd4
  } windtx_state_t;

  function automatic lane_t lane_onehot(input slot_t idx);
    lane_t mask;
    mask      = '0;
    mask[idx] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/windtx_burst.sv
// -----------------------------------------------------------------------------
// windtx_burst
// Carrier generator for one excitation burst: N_PULSES periods, each
// HALF_PERIOD cycles high followed by HALF_PERIOD cycles low.
//   clock   : clock
//   reset   : synchronous, active-high
//   go      : load pulse; the cycle after it is the first (high) burst cycle
//   carrier : registered carrier level for the current cycle
//   last    : high during the final (low) cycle of the burst
// -----------------------------------------------------------------------------
module windtx_burst
  import windtx_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 625,
  parameter int unsigned N_PULSES    = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic go,
  output logic carrier,
  output logic last
);

  localparam cnt_t       HALF_LOAD  = cnt_t'(HALF_PERIOD - 1);
  localparam pulse_cnt_t PULSE_LOAD = pulse_cnt_t'(N_PULSES - 1);

  logic       active_q,  active_d;
  logic       carrier_q, carrier_d;
  cnt_t       half_q,    half_d;
  pulse_cnt_t pulse_q,   pulse_d;
  logic       half_end;

  assign half_end = (half_q == '0);

  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    active_d  = active_q;
    carrier_d = carrier_q;
    half_d    = half_q;
    pulse_d   = pulse_q;

    if (go) begin
      active_d  = 1'b1;
      carrier_d = 1'b1;
      half_d    = HALF_LOAD;
      pulse_d   = PULSE_LOAD;
    end else if (active_q) begin
      if (!half_end) begin
        half_d = half_q - cnt_t'(1);
      end else begin
        half_d = HALF_LOAD;
        if (carrier_q) begin
          carrier_d = 1'b0;
        end else if (pulse_q == '0) begin
          // End of the last low half: park low and stop.
          active_d = 1'b0;
        end else begin
          carrier_d = 1'b1;
          pulse_d   = pulse_q - pulse_cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    if (reset) begin
      active_q  <= 1'b0;
      carrier_q <= 1'b0;
      half_q    <= '0;
      pulse_q   <= '0;
    end else begin
      active_q  <= active_d;
      carrier_q <= carrier_d;
      half_q    <= half_d;
      pulse_q   <= pulse_d;
    end
  end

  assign carrier = carrier_q;
  assign last    = active_q && !carrier_q && half_end && (pulse_q == '0);

endmodule

// File: rtl/windtx.sv
// -----------------------------------------------------------------------------
// windtx
// Transmit-side sequencer of the wind-direction front end. One sweep services
// the four transducers in order: carrier burst, ring-down blanking, capture
// window (endata), echo-decay guard.
//   clock  : clock
//   reset  : synchronous, active-high
//   start  : request a sweep (sampled only in IDLE)
//   abort  : terminate the sweep; IDLE on the next cycle
//   tx_p   : positive drive per lane (carrier on the active lane)
//   tx_n   : negative drive per lane (inverted carrier on the active lane)
//   endata : receive capture window
//   slot   : transducer currently serviced (held in IDLE)
//   busy   : sweep in progress
//   done   : one-cycle pulse on normal sweep completion
// -----------------------------------------------------------------------------
module windtx
  import windtx_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 625,
  parameter int unsigned N_PULSES    = 8,
  parameter int unsigned BLANK_LEN   = 2000,
  parameter int unsigned LISTEN_LEN  = 25000,
  parameter int unsigned GUARD_LEN   = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic [WINDTX_LANES-1:0] tx_p,
  output logic [WINDTX_LANES-1:0] tx_n,
  output logic                    endata,
  output logic [1:0]              slot,
  output logic                    busy,
  output logic                    done
);

  localparam cnt_t  BLANK_LOAD  = cnt_t'(BLANK_LEN - 1);
  localparam cnt_t  LISTEN_LOAD = cnt_t'(LISTEN_LEN - 1);
  localparam cnt_t  GUARD_LOAD  = cnt_t'(GUARD_LEN - 1);
  localparam slot_t LAST_SLOT   = slot_t'(WINDTX_LANES - 1);

  windtx_state_t state_q, state_d;
  cnt_t          cnt_q,   cnt_d;
  slot_t         slot_q,  slot_d;
  lane_t         lane_q,  lane_d;
  logic          endata_q, endata_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;

  logic burst_go;
  logic burst_carrier;
  logic burst_last;
  logic cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  windtx_burst #(
    .HALF_PERIOD (HALF_PERIOD),
    .N_PULSES    (N_PULSES)
  ) u_burst (
    .clock   (clock),
    .reset   (reset),
    .go      (burst_go),
    .carrier (burst_carrier),
    .last    (burst_last)
  );

  // State register: FSM state, counters and all output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      slot_q   <= '0;
      lane_q   <= '0;
      endata_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      lane_q   <= lane_d;
      endata_q <= endata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. One down-counter is reloaded on each phase entry and
  // the phase ends on the cycle it reads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;

    if (state_q != ST_IDLE && abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            state_d = ST_BURST;
            slot_d  = '0;
          end
        end
        ST_BURST: begin
          if (burst_last) begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_LOAD;
          end
        end
        ST_BLANK: begin
          if (cnt_zero) begin
            state_d = ST_LISTEN;
            cnt_d   = LISTEN_LOAD;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
        ST_LISTEN: begin
          if (cnt_zero) begin
            state_d = ST_GUARD;
            cnt_d   = GUARD_LOAD;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
        ST_GUARD: begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - cnt_t'(1);
          end else if (slot_q == LAST_SLOT) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_BURST;
            slot_d  = slot_q + slot_t'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic, computed from the next state so the registered outputs
  // line up with the state they describe.
  always_comb begin
    burst_go = (state_d == ST_BURST) && (state_q != ST_BURST);
    busy_d   = (state_d != ST_IDLE);
    endata_d = (state_d == ST_LISTEN);
    lane_d   = (state_d == ST_BURST) ? lane_onehot(slot_d) : '0;
    // Normal completion only: an abort in the final GUARD cycle suppresses it.
    done_d   = (state_q == ST_GUARD) && (state_d == ST_IDLE) && !abort;
  end

  // The lane mask and the carrier are both flops; the drive is their AND.
  assign tx_p   = lane_q & {WINDTX_LANES{burst_carrier}};
  assign tx_n   = lane_q & {WINDTX_LANES{~burst_carrier}};
  assign endata = endata_q;
  assign slot   = slot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_windtx.sv
// -----------------------------------------------------------------------------
// tb_windtx
// Directed scenarios for windtx with HALF_PERIOD=2, N_PULSES=3, BLANK_LEN=4,
// LISTEN_LEN=5, GUARD_LEN=3 (slot period T=24, sweep ends at cycle 97).
// Stimulus pushes hand-computed expectations, tagged with the absolute cycle,
// into a scoreboard; a monitor samples on the falling edge and retires every
// expectation due in that cycle.
// -----------------------------------------------------------------------------
module tb_windtx;

  localparam int unsigned HP = 2;
  localparam int unsigned NP = 3;
  localparam int unsigned BL = 4;
  localparam int unsigned LL = 5;
  localparam int unsigned GL = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] tx_p;
  logic [3:0] tx_n;
  logic       endata;
  logic [1:0] slot;
  logic       busy;
  logic       done;

  windtx #(
    .HALF_PERIOD (HP),
    .N_PULSES    (NP),
    .BLANK_LEN   (BL),
    .LISTEN_LEN  (LL),
    .GUARD_LEN   (GL)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .tx_p   (tx_p),
    .tx_n   (tx_n),
    .endata (endata),
    .slot   (slot),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  typedef enum {SIG_TXP, SIG_TXN, SIG_ENDATA, SIG_SLOT, SIG_BUSY, SIG_DONE} sig_e;

  typedef struct {
    sig_e       sig;
    int         at;
    int         rel;
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   base     = 0;
  int   total    = 0;
  int   bad      = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  function automatic logic [3:0] sample(input sig_e s);
    case (s)
      SIG_TXP:    return tx_p;
      SIG_TXN:    return tx_n;
      SIG_ENDATA: return {3'b000, endata};
      SIG_SLOT:   return {2'b00, slot};
      SIG_BUSY:   return {3'b000, busy};
      default:    return {3'b000, done};
    endcase
  endfunction

  task automatic check(input string name, input int rel,
                       input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, rel, act, exp);
    end
  endtask

  task automatic expect_at(input sig_e s, input int k, input logic [3:0] v,
                           input string nm);
    exp_t e;
    e.sig  = s;
    e.at   = base + k;
    e.rel  = k;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: retire every expectation due in the current cycle.
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == edge_cnt) begin
        check(sb[i].name, sb[i].rel, sample(sb[i].sig), sb[i].exp);
        sb.delete(i);
      end else if (sb[i].at < edge_cnt) begin
        total++;
        bad++;
        $display("FAIL %s @cycle %0d: not sampled, expected %h",
                 sb[i].name, sb[i].rel, sb[i].exp);
        sb.delete(i);
      end
    end
  end

  // Returns just after the edge that opens cycle k of the current scenario.
  task automatic wait_to(input int k);
    while (edge_cnt < base + k) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Opens a new scenario: the cycle entered here is reference cycle 0.
  task automatic new_base();
    @(posedge clock);
    #1;
    base = edge_cnt;
  endtask

  task automatic expect_idle(input int k, input logic [1:0] s, input string nm);
    expect_at(SIG_TXP,    k, 4'h0,          {nm, ".tx_p"});
    expect_at(SIG_TXN,    k, 4'h0,          {nm, ".tx_n"});
    expect_at(SIG_ENDATA, k, 4'h0,          {nm, ".endata"});
    expect_at(SIG_SLOT,   k, {2'b00, s},    {nm, ".slot"});
    expect_at(SIG_BUSY,   k, 4'h0,          {nm, ".busy"});
    expect_at(SIG_DONE,   k, 4'h0,          {nm, ".done"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;

    // Reset state.
    new_base();
    expect_idle(1, 2'd0, "reset");
    wait_to(2);
    reset = 1'b0;
    wait_to(4);

    // Full sweep from a single start pulse.
    new_base();
    start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      expect_at(SIG_TXP, k, (((k - 1) % 4) < 2) ? 4'b0001 : 4'b0000, "sweep.tx_p0");
      expect_at(SIG_TXN, k, (((k - 1) % 4) < 2) ? 4'b0000 : 4'b0001, "sweep.tx_n0");
    end
    for (int k = 16; k <= 22; k++)
      expect_at(SIG_ENDATA, k, {3'b000, (k >= 17 && k <= 21)}, "sweep.endata");
    for (int k = 17; k <= 21; k++)
      expect_at(SIG_SLOT, k, 4'd0, "sweep.slot_listen");
    expect_at(SIG_TXP, 24, 4'b0000, "sweep.tx_p_guard0");
    expect_at(SIG_TXP, 25, 4'b0010, "sweep.tx_p1_rise");
    expect_at(SIG_TXP, 72, 4'b0000, "sweep.tx_p_guard2");
    expect_at(SIG_TXP, 73, 4'b1000, "sweep.tx_p3_rise");
    for (int k = 1; k <= 99; k++)
      expect_at(SIG_DONE, k, {3'b000, (k == 97)}, "sweep.done");
    expect_at(SIG_BUSY, 0,  4'd0, "sweep.busy_c0");
    expect_at(SIG_BUSY, 1,  4'd1, "sweep.busy_c1");
    expect_at(SIG_BUSY, 96, 4'd1, "sweep.busy_c96");
    expect_at(SIG_BUSY, 97, 4'd0, "sweep.busy_c97");
    expect_at(SIG_SLOT, 97, 4'd3, "sweep.slot_end");
    expect_at(SIG_SLOT, 99, 4'd3, "sweep.slot_hold");
    wait_to(1);
    start = 1'b0;
    wait_to(100);

    // Abort during slot 1 burst.
    new_base();
    start = 1'b1;
    expect_at(SIG_TXP, 30, 4'b0010, "abort.tx_p_before");
    expect_idle(31, 2'd1, "abort.c31");
    for (int k = 1; k <= 110; k++)
      expect_at(SIG_DONE, k, 4'd0, "abort.done");
    for (int k = 32; k <= 40; k++)
      expect_at(SIG_BUSY, k, 4'd0, "abort.busy_after");
    wait_to(1);
    start = 1'b0;
    wait_to(30);
    abort = 1'b1;
    wait_to(31);
    abort = 1'b0;
    wait_to(111);

    // Start re-pulsed while busy is ignored.
    new_base();
    start = 1'b1;
    expect_at(SIG_SLOT, 6,  4'd0,    "repulse.slot_c6");
    expect_at(SIG_TXP,  6,  4'b0001, "repulse.tx_p_c6");
    expect_at(SIG_SLOT, 51, 4'd2,    "repulse.slot_c51");
    for (int k = 1; k <= 99; k++)
      expect_at(SIG_DONE, k, {3'b000, (k == 97)}, "repulse.done");
    expect_at(SIG_BUSY, 97, 4'd0, "repulse.busy_c97");
    wait_to(1);
    start = 1'b0;
    wait_to(5);
    start = 1'b1;
    wait_to(6);
    start = 1'b0;
    wait_to(50);
    start = 1'b1;
    wait_to(51);
    start = 1'b0;
    wait_to(100);

    // Reset during LISTEN, then a fresh sweep.
    new_base();
    start = 1'b1;
    expect_at(SIG_ENDATA, 18, 4'd1, "rst.endata_c18");
    expect_idle(19, 2'd0, "rst.c19");
    wait_to(1);
    start = 1'b0;
    wait_to(18);
    reset = 1'b1;
    wait_to(19);
    reset = 1'b0;
    wait_to(22);
    new_base();
    start = 1'b1;
    expect_at(SIG_TXP,  1,  4'b0001, "rst2.tx_p_c1");
    expect_at(SIG_SLOT, 1,  4'd0,    "rst2.slot_c1");
    expect_at(SIG_BUSY, 1,  4'd1,    "rst2.busy_c1");
    expect_at(SIG_ENDATA, 17, 4'd1,  "rst2.endata_c17");
    expect_at(SIG_TXP,  25, 4'b0010, "rst2.tx_p1_rise");
    wait_to(1);
    start = 1'b0;
    wait_to(26);
    abort = 1'b1;
    wait_to(27);
    abort = 1'b0;
    wait_to(29);

    // Start held high: back-to-back sweeps through one IDLE cycle.
    new_base();
    start = 1'b1;
    for (int k = 1; k <= 196; k++)
      expect_at(SIG_DONE, k, {3'b000, (k == 97 || k == 194)}, "held.done");
    expect_at(SIG_BUSY, 97,  4'd0,    "held.busy_c97");
    expect_at(SIG_SLOT, 97,  4'd3,    "held.slot_c97");
    expect_at(SIG_BUSY, 98,  4'd1,    "held.busy_c98");
    expect_at(SIG_TXP,  98,  4'b0001, "held.tx_p_c98");
    expect_at(SIG_SLOT, 98,  4'd0,    "held.slot_c98");
    expect_at(SIG_BUSY, 195, 4'd0,    "held.busy_c195");
    wait_to(193);
    start = 1'b0;
    wait_to(197);

    // Start and abort together in IDLE: abort wins.
    new_base();
    start = 1'b1;
    abort = 1'b1;
    expect_at(SIG_BUSY, 1, 4'd0, "both.busy_c1");
    expect_at(SIG_BUSY, 2, 4'd0, "both.busy_c2");
    expect_at(SIG_TXP,  1, 4'd0, "both.tx_p_c1");
    expect_at(SIG_DONE, 1, 4'd0, "both.done_c1");
    wait_to(1);
    start = 1'b0;
    abort = 1'b0;
    wait_to(3);

    // Drain, bounded.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    while (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s @cycle %0d: never sampled", sb[0].name, sb[0].rel);
      void'(sb.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/windtx.md
# windtx

Ultrasonic excitation and measurement sequencer: the transmit end of the wind-direction front end. On `start`, it runs one sweep over the four transducers in fixed order. For each transducer it drives a complementary carrier burst, blanks ring-down, then opens the `endata` capture window that the wind/direction receive path uses to accept ADC samples. It also reports which transducer fired, so receive-side time-of-flight results are attributed to the right slot.

## Interface
- `HALF_PERIOD`, default 625: clock cycles per carrier half-period (40 kHz at 50 MHz). Range 1..2^24-1.
- `N_PULSES`, default 8: carrier periods per burst. Range 1..255.
- `BLANK_LEN`, default 2000: dead cycles after the burst, before listening. Range 1..2^24-1.
- `LISTEN_LEN`, default 25000: cycles `endata` is held high per slot. Range 1..2^24-1.
- `GUARD_LEN`, default 50000: echo-decay cycles after listening, before the next slot. Range 1..2^24-1.
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a sweep. Sampled only in IDLE.
- `abort` in 1: terminate the sweep. Takes effect the next cycle.
- `tx_p` out 4: positive drive, one lane per transducer.
- `tx_n` out 4: negative drive, the complement of `tx_p` on the active lane.
- `endata` out 1: capture window for the receive path.
- `slot` out 2: index of the transducer currently being serviced.
- `busy` out 1: a sweep is in progress.
- `done` out 1: one-cycle pulse when a sweep completes normally.

## Operation
- States: IDLE, BURST, BLANK, LISTEN, GUARD.
- IDLE → BURST when `start`=1 and `abort`=0. `slot` is cleared to 0 on this entry.
- BURST lasts 2·N_PULSES·HALF_PERIOD cycles. The carrier is high for HALF_PERIOD cycles, then low for HALF_PERIOD cycles, repeated N_PULSES times, so the first burst cycle is high and the last is low.
  - Active lane: `tx_p[slot]` = carrier, `tx_n[slot]` = ~carrier.
  - All other lanes: 0 on both outputs.
- BLANK lasts BLANK_LEN cycles. All drives are 0 and `endata`=0.
- LISTEN lasts LISTEN_LEN cycles with `endata`=1. Drives are 0.
- GUARD lasts GUARD_LEN cycles. Drives are 0 and `endata`=0.
- Exit from GUARD:
  - If `slot`<3: `slot` increments and the state returns to BURST.
  - If `slot`=3: the state goes to IDLE and `done`=1 for that first IDLE cycle.
- `busy`=1 in every non-IDLE state.
- `slot` holds its value in IDLE; after a completed sweep it reads 3.
- `abort`=1 in any non-IDLE state:
  - The next cycle is IDLE with all outputs 0 except `slot` (held).
  - No `done` pulse is produced.
- `abort` has priority over `start` when both are high in IDLE.
- `start` while `busy` is ignored and is not queued.
- `start` held high continuously: the sweep restarts from the `done` cycle, because IDLE is always visited for at least one cycle.
- Counter widths:
  - Shared 24-bit down-counter for phase durations.
  - Separate 24-bit half-period counter.
  - 8-bit pulse counter.
  - No wrap is possible for the legal parameter ranges.

## Timing
- Reset (sampled high at an edge): next cycle is IDLE, and `tx_p`=`tx_n`=0, `endata`=0, `slot`=0, `busy`=0, `done`=0.
- Every output is registered, with no combinational path from any input to any output.
- Reference cycle 0 is a cycle where `start`=1 is sampled in IDLE. From there:
  - BURST for slot 0 occupies cycles 1..2NH.
  - `endata` is high in cycles 1+2NH+B .. 2NH+B+L.
  - Slot period T = 2NH + B + L + G.
  - Slot k burst begins at cycle 1+kT.
  - `busy` is high for cycles 1..4T.
  - `done` is high at cycle 4T+1.
- `abort` sampled at cycle c: cycle c+1 is IDLE with all drives and `endata` low.

## Structure
- Package `windtx_pkg`:
  - state enum typedef `windtx_state_t`
  - `WINDTX_LANES`=4
  - `WINDTX_CNT_W`=24
- Sub-module `windtx_burst`: carrier generator.
  - Inputs: clock, reset, `go`, `HALF_PERIOD`/`N_PULSES` parameters.
  - Outputs: `carrier`, `last` (high on the final burst cycle).
  - The top FSM uses `last` for the BURST→BLANK transition.
- The top-level module owns the FSM, the phase down-counter, the slot counter, and the lane decode.

## Test plan
Parameters for all scenarios: HALF_PERIOD=2, N_PULSES=3, BLANK_LEN=4, LISTEN_LEN=5, GUARD_LEN=3, giving T=24.
- Full sweep, start pulse at cycle 0:
  - `tx_p[0]` = 1,1,0,0 repeated 3 times over cycles 1–12; `tx_n[0]` is its complement.
  - `endata` is high in cycles 17–21 with `slot`=0.
  - `tx_p[1]` first rises at cycle 25; `tx_p[3]` at cycle 73.
  - `done` is high only at cycle 97; `busy` falls at cycle 97.
- Abort at cycle 30 (slot 1, BURST):
  - Cycle 31: `tx_p`=`tx_n`=0, `busy`=0, `slot`=1.
  - `done` never pulses.
- `start` re-pulsed at cycles 5 and 50: no effect; `done` still occurs at cycle 97 only.
- `reset` asserted at cycle 18 (during LISTEN): cycle 19 shows all outputs 0 and `slot`=0; the next `start` begins a fresh sweep from slot 0.
- `start` held high from cycle 0: `done` at cycle 97, the next burst begins at cycle 98, `done` again at cycle 194.
- `start` and `abort` both high in IDLE: the block stays IDLE and `busy` remains 0.
